// File: rtl/thermostat_pkg.sv
// Shared types and register-map constants for the multi-zone thermostat.
package thermostat_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_HEAT  = 2'd1,
        MODE_COOL  = 2'd2,
        MODE_FAULT = 2'd3
    } mode_e;

    localparam logic [3:0] SP_BASE   = 4'd0;
    localparam logic [3:0] STAT_BASE = 4'd8;

    localparam int unsigned STAT_TEMP_LSB = 0;
    localparam int unsigned STAT_MODE_LSB = 16;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability debounce and
// auto-repeat step pulse generator.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 50000,
    parameter int unsigned REPEAT_CYC   = 12500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    input  logic i_inhibit,
    output logic o_level,
    output logic o_step
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned RW = $clog2(REPEAT_CYC + 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYC - 1);

    logic [1:0]    r_sync;
    logic [DW-1:0] r_db_cnt;
    logic          r_level;
    logic          r_level_q;
    logic [RW-1:0] r_rep;
    logic          r_step;
    logic          w_rise;

    assign w_rise  = r_level & ~r_level_q;
    assign o_level = r_level;
    assign o_step  = r_step;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync    <= '0;
            r_db_cnt  <= '0;
            r_level   <= 1'b0;
            r_level_q <= 1'b0;
            r_rep     <= '0;
            r_step    <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_raw};
            r_level_q <= r_level;
            // Counter runs only while the synchronised level disagrees with the debounced one.
            if (r_sync[1] == r_level) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_LAST) begin
                r_level  <= r_sync[1];
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DW'(1);
            end

            r_step <= 1'b0;
            if (i_inhibit || !r_level) begin
                r_rep <= '0;
            end else if (w_rise || r_rep == REP_LAST) begin
                r_step <= 1'b1;
                r_rep  <= '0;
            end else begin
                r_rep <= r_rep + RW'(1);
            end
        end
    end

endmodule

// File: rtl/zone_thermostat_ctrl.sv
// Multi-zone thermostat: per-zone setpoints (buttons or Avalon-MM), hysteresis
// heat/cool FSM and sample-timeout fault detection.
module zone_thermostat_ctrl
    import thermostat_pkg::*;
#(
    parameter int unsigned NUM_ZONES    = 4,
    parameter int unsigned TEMP_W       = 8,
    parameter int unsigned TEMP_MIN     = 16,
    parameter int unsigned TEMP_MAX     = 30,
    parameter int unsigned SET_DEFAULT  = 22,
    parameter int unsigned HYST         = 2,
    parameter int unsigned DEBOUNCE_CYC = 50000,
    parameter int unsigned REPEAT_CYC   = 12500000,
    parameter int unsigned TIMEOUT_CYC  = 50000000
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic [1:0]                    btn,
    input  logic [2:0]                    zone_sel,
    input  logic [NUM_ZONES*TEMP_W-1:0]   temp_meas,
    input  logic [NUM_ZONES-1:0]          temp_valid,
    input  logic [3:0]                    avs_address,
    input  logic                          avs_read,
    input  logic                          avs_write,
    input  logic [31:0]                   avs_writedata,
    output logic [31:0]                   avs_readdata,
    output logic [NUM_ZONES-1:0]          heat,
    output logic [NUM_ZONES-1:0]          cool,
    output logic [NUM_ZONES*TEMP_W-1:0]   setpoint_flat,
    output logic [NUM_ZONES-1:0]          fault
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]     TMO_MAX  = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TEMP_W-1:0] SP_MIN   = TEMP_W'(TEMP_MIN);
    localparam logic [TEMP_W-1:0] SP_MAX   = TEMP_W'(TEMP_MAX);
    localparam logic [TEMP_W-1:0] SP_DEF   = TEMP_W'(SET_DEFAULT);
    localparam logic [TEMP_W:0]   HYST_X   = (TEMP_W+1)'(HYST);

    function automatic logic [TEMP_W-1:0] f_clamp(input logic [TEMP_W-1:0] v);
        if (v < SP_MIN)      return SP_MIN;
        else if (v > SP_MAX) return SP_MAX;
        else                 return v;
    endfunction

    logic [TEMP_W-1:0] r_sp    [NUM_ZONES];
    logic [TEMP_W-1:0] r_temp  [NUM_ZONES];
    logic [TW-1:0]     r_tmo   [NUM_ZONES];
    mode_e             r_state [NUM_ZONES];
    mode_e             w_nxt   [NUM_ZONES];
    logic [NUM_ZONES-1:0] r_heat, r_cool, r_fault;
    logic [31:0]       r_readdata;
    logic [31:0]       w_rdata;

    logic        w_lvl_up, w_lvl_dn, w_step_up, w_step_dn, w_inhibit;
    logic        w_is_stat, w_wr_sp;
    logic [3:0]  w_off;
    logic [31:0] w_aidx, w_sidx;
    logic [TEMP_W:0] w_t9, w_sp9;
    logic        w_unused_wdata;

    assign w_inhibit      = w_lvl_up & w_lvl_dn;
    assign w_is_stat      = (avs_address >= STAT_BASE);
    assign w_off          = w_is_stat ? (avs_address - STAT_BASE) : (avs_address - SP_BASE);
    assign w_aidx         = 32'(w_off);
    assign w_sidx         = 32'(zone_sel);
    assign w_wr_sp        = avs_write & ~w_is_stat;
    assign w_unused_wdata = ^avs_writedata[31:TEMP_W];

    assign avs_readdata = r_readdata;
    assign heat         = r_heat;
    assign cool         = r_cool;
    assign fault        = r_fault;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_CYC(REPEAT_CYC)) u_btn_up (
        .i_clk(clk_clk), .i_rst_n(reset_reset_n), .i_raw(btn[0]),
        .i_inhibit(w_inhibit), .o_level(w_lvl_up), .o_step(w_step_up)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_CYC(REPEAT_CYC)) u_btn_dn (
        .i_clk(clk_clk), .i_rst_n(reset_reset_n), .i_raw(btn[1]),
        .i_inhibit(w_inhibit), .o_level(w_lvl_dn), .o_step(w_step_dn)
    );

    // A valid sample takes priority over the timeout so FAULT can always be cleared.
    always_comb begin
        w_t9  = '0;
        w_sp9 = '0;
        for (int unsigned z = 0; z < NUM_ZONES; z++) begin
            w_nxt[z] = r_state[z];
            w_t9     = {1'b0, temp_meas[z*TEMP_W +: TEMP_W]};
            w_sp9    = {1'b0, r_sp[z]};
            if (temp_valid[z]) begin
                case (r_state[z])
                    MODE_IDLE: begin
                        if (w_t9 <= w_sp9 - HYST_X)      w_nxt[z] = MODE_HEAT;
                        else if (w_t9 >= w_sp9 + HYST_X) w_nxt[z] = MODE_COOL;
                    end
                    MODE_HEAT:  if (w_t9 >= w_sp9) w_nxt[z] = MODE_IDLE;
                    MODE_COOL:  if (w_t9 <= w_sp9) w_nxt[z] = MODE_IDLE;
                    default:    w_nxt[z] = MODE_IDLE;
                endcase
            end else if (r_tmo[z] == TMO_LAST) begin
                w_nxt[z] = MODE_FAULT;
            end
        end
    end

    always_comb begin
        w_rdata       = '0;
        setpoint_flat = '0;
        for (int unsigned z = 0; z < NUM_ZONES; z++) begin
            setpoint_flat[z*TEMP_W +: TEMP_W] = r_sp[z];
            if (w_aidx == z) begin
                if (!w_is_stat) begin
                    w_rdata[TEMP_W-1:0] = r_sp[z];
                end else begin
                    w_rdata[STAT_TEMP_LSB +: TEMP_W] = r_temp[z];
                    w_rdata[STAT_MODE_LSB +: 2]      = r_state[z];
                end
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            for (int unsigned z = 0; z < NUM_ZONES; z++) begin
                r_sp[z]    <= SP_DEF;
                r_temp[z]  <= '0;
                r_tmo[z]   <= '0;
                r_state[z] <= MODE_IDLE;
            end
            r_heat     <= '0;
            r_cool     <= '0;
            r_fault    <= '0;
            r_readdata <= '0;
        end else begin
            for (int unsigned z = 0; z < NUM_ZONES; z++) begin
                r_state[z] <= w_nxt[z];
                r_heat[z]  <= (w_nxt[z] == MODE_HEAT);
                r_cool[z]  <= (w_nxt[z] == MODE_COOL);
                r_fault[z] <= (w_nxt[z] == MODE_FAULT);
                if (temp_valid[z]) begin
                    r_temp[z] <= temp_meas[z*TEMP_W +: TEMP_W];
                    r_tmo[z]  <= '0;
                end else if (r_tmo[z] != TMO_MAX) begin
                    r_tmo[z] <= r_tmo[z] + TW'(1);
                end
                if (w_wr_sp && w_aidx == z) begin
                    r_sp[z] <= f_clamp(avs_writedata[TEMP_W-1:0]);
                end else if (w_sidx == z) begin
                    if (w_step_up && r_sp[z] < SP_MAX)      r_sp[z] <= r_sp[z] + TEMP_W'(1);
                    else if (w_step_dn && r_sp[z] > SP_MIN) r_sp[z] <= r_sp[z] - TEMP_W'(1);
                end
            end
            r_readdata <= avs_read ? w_rdata : '0;
        end
    end

endmodule

// File: tb/tb_zone_thermostat_ctrl.sv
// Scoreboard bench for zone_thermostat_ctrl with shortened timing parameters.
module tb_zone_thermostat_ctrl;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [1:0]  btn;
    logic [2:0]  zone_sel;
    logic [31:0] temp_meas;
    logic [3:0]  temp_valid;
    logic [3:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic [3:0]  heat, cool, fault;
    logic [31:0] setpoint_flat;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk_clk = ~clk_clk;

    zone_thermostat_ctrl #(
        .NUM_ZONES(4), .DEBOUNCE_CYC(4), .REPEAT_CYC(16), .TIMEOUT_CYC(64)
    ) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .btn(btn), .zone_sel(zone_sel),
        .temp_meas(temp_meas), .temp_valid(temp_valid), .avs_address(avs_address),
        .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata), .heat(heat), .cool(cool),
        .setpoint_flat(setpoint_flat), .fault(fault)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic avs_wr(input logic [3:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        tick();
        avs_write = 1'b0;
    endtask

    task automatic avs_rd(input logic [3:0] a, input logic [31:0] e, input string t);
        avs_address = a; avs_read = 1'b1;
        exp_q.push_back(e);
        tag_q.push_back(t);
        tick();
        avs_read = 1'b0;
    endtask

    task automatic strobe(input int unsigned z, input logic [7:0] t);
        temp_meas[z*8 +: 8] = t;
        temp_valid[z] = 1'b1;
        tick();
        temp_valid = '0;
    endtask

    // Read-data side of the scoreboard: one-cycle latency after each read strobe.
    always @(posedge clk_clk) begin
        if (avs_read) begin
            #1;
            if (exp_q.size() == 0) chk("rd_underflow", 32'd1, 32'd0);
            else chk(tag_q.pop_front(), avs_readdata, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] sp_def;
        logic [7:0]  bounce [8];
        int unsigned k;
        int unsigned dev;
        sp_def = {4{8'd22}};
        bounce = '{1, 1, 0, 1, 1, 1, 0, 0};

        reset_reset_n = 1'b0; btn = '0; zone_sel = '0; temp_meas = '0; temp_valid = '0;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        repeat (3) tick();
        reset_reset_n = 1'b1;
        tick();

        chk("rst_heat", 32'(heat), 32'd0);
        chk("rst_cool", 32'(cool), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_rdata", avs_readdata, 32'd0);
        chk("rst_flat", setpoint_flat, sp_def);
        for (int unsigned a = 0; a < 4; a++) avs_rd(4'(a), 32'd22, "rst_sp");
        for (int unsigned a = 8; a < 12; a++) avs_rd(4'(a), 32'd0, "rst_stat");

        // Zone 0 hysteresis with SP = 22
        strobe(0, 8'd21); chk("z0_s21_heat", 32'(heat[0]), 32'd0);
        avs_rd(4'd8, 32'd21, "z0_stat21");
        strobe(0, 8'd20); chk("z0_s20_heat", 32'(heat[0]), 32'd1);
        avs_rd(4'd8, (32'd1 << 16) | 32'd20, "z0_stat20");
        strobe(0, 8'd21); chk("z0_s21b_heat", 32'(heat[0]), 32'd1);
        chk("z0_cool", 32'(cool[0]), 32'd0);
        strobe(0, 8'd22); chk("z0_s22_heat", 32'(heat[0]), 32'd0);
        avs_rd(4'd8, 32'd22, "z0_stat22");

        // Buttons on zone 1
        zone_sel = 3'd1;
        for (int i = 0; i < 8; i++) begin btn[0] = bounce[i][0]; tick(); end
        repeat (10) tick();
        chk("bounce", 32'(setpoint_flat[15:8]), 32'd22);

        btn = 2'b01;
        k = 0;
        while (setpoint_flat[15:8] == 8'd22 && k < 40) begin tick(); k++; end
        chk("up_first", 32'(setpoint_flat[15:8]), 32'd23);
        repeat (36) tick();
        chk("up_repeat", 32'(setpoint_flat[15:8]), 32'd25);
        repeat (176) tick();
        chk("up_sat", 32'(setpoint_flat[15:8]), 32'd30);
        btn = 2'b00;
        repeat (12) tick();
        avs_rd(4'd1, 32'd30, "sp1_sat");

        // Avalon setpoint writes with clamping
        avs_wr(4'd2, 32'd40);          avs_rd(4'd2, 32'd30, "wr40_clamp");
        avs_wr(4'd2, 32'd5);           avs_rd(4'd2, 32'd16, "wr5_clamp");
        avs_wr(4'd2, 32'd31);          avs_rd(4'd2, 32'd30, "wr31_clamp");
        avs_wr(4'd2, 32'h0000_0119);   avs_rd(4'd2, 32'd25, "wr_hibits");
        chk("flat_z2", 32'(setpoint_flat[23:16]), 32'd25);
        avs_wr(4'd6, 32'd25);          avs_rd(4'd6, 32'd0, "addr6");
        avs_rd(4'd14, 32'd0, "stat_z6");
        avs_wr(4'd10, 32'd18);         avs_rd(4'd2, 32'd25, "stat_ro");

        // Continuous write vs down steps on zone 1: the write must win every cycle
        zone_sel = 3'd1; btn = 2'b10;
        avs_address = 4'd1; avs_writedata = 32'd20; avs_write = 1'b1;
        dev = 0;
        for (int i = 0; i < 60; i++) begin
            if (i == 40) btn = 2'b00;
            tick();
            if (setpoint_flat[15:8] != 8'd20) dev++;
        end
        avs_write = 1'b0;
        chk("wr_wins", dev, 32'd0);
        avs_rd(4'd1, 32'd20, "wr_kept");

        btn = 2'b10; repeat (12) tick(); btn = 2'b00; repeat (12) tick();
        avs_rd(4'd1, 32'd19, "down_step");
        btn = 2'b11; repeat (40) tick(); btn = 2'b00; repeat (12) tick();
        chk("both_held", 32'(setpoint_flat[15:8]), 32'd19);

        // Zone 3 timeout (zone 3 is already faulted; the first sample only clears it)
        strobe(3, 8'd22);
        chk("z3_clear", 32'(fault[3]), 32'd0);
        repeat (63) tick();
        chk("z3_tmo_63", 32'(fault[3]), 32'd0);
        tick();
        chk("z3_tmo_64", 32'(fault[3]), 32'd1);
        avs_rd(4'd11, (32'd3 << 16) | 32'd22, "z3_stat_fault");
        strobe(3, 8'd25);
        chk("z3_idle_fault", 32'(fault[3]), 32'd0);
        chk("z3_idle_cool", 32'(cool[3]), 32'd0);
        avs_rd(4'd11, 32'd25, "z3_stat_idle");
        strobe(3, 8'd25);
        chk("z3_cool", 32'(cool[3]), 32'd1);
        chk("z3_heat", 32'(heat[3]), 32'd0);
        avs_rd(4'd11, (32'd2 << 16) | 32'd25, "z3_stat_cool");

        // Reset mid-operation
        reset_reset_n = 1'b0;
        tick();
        chk("mid_rst_cool", 32'(cool), 32'd0);
        chk("mid_rst_fault", 32'(fault), 32'd0);
        chk("mid_rst_flat", setpoint_flat, sp_def);
        reset_reset_n = 1'b1;
        tick();
        avs_rd(4'd1, 32'd22, "mid_rst_sp1");
        avs_rd(4'd11, 32'd0, "mid_rst_stat3");

        repeat (3) tick();
        if (exp_q.size() != 0) chk("rd_pending", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
